// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter and sequencer for the shared 8:1 data mux
//
// Eight requesters share one downstream port. The block picks one requester
// in rotating-priority order, drives the embedded 8:1 mux, and holds that
// selection until the downstream side accepts the word via out_valid/out_ready.
//
// Optional feature macro: MUX_ARB_LOCK_EN (adds the lock input for burst holds).
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   req        request bit per requester (index 0..7)
//   din        packed words, requester i at bits [i*WIDTH +: WIDTH]
//   out_ready  downstream accepts dout this cycle
//   lock       (MUX_ARB_LOCK_EN only) keep the current grant across handshakes
//   gnt        one-hot grant, registered
//   sel        index of the granted requester, registered
//   out_valid  dout holds a valid word, registered
//   dout       din slice picked by sel, combinational

module mux_rr_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           req,
    input  logic [8*WIDTH-1:0]   din,
    input  logic                 out_ready,
`ifdef MUX_ARB_LOCK_EN
    input  logic                 lock,
`endif
    output logic [7:0]           gnt,
    output logic [2:0]           sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     dout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       release_grant;

    // Scan from the lowest-priority offset up to ptr itself so the last hit,
    // which is the one that survives, is the first set bit in priority order.
    // The 3-bit add wraps naturally, giving the mod-8 rotation.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    // A handshake normally releases the grant; with lock asserted and the
    // owner still requesting, the grant is kept for a back-to-back transfer.
`ifdef MUX_ARB_LOCK_EN
    assign release_grant = out_ready && !(lock && req[sel]);
`else
    assign release_grant = out_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            sel       <= 3'd0;
            gnt       <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= BUSY;
                        sel       <= winner;
                        gnt       <= 8'b1 << winner;
                        out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    // No re-arbitration while busy, even if req[sel] drops.
                    if (release_grant) begin
                        state     <= IDLE;
                        gnt       <= 8'd0;
                        out_valid <= 1'b0;
                        ptr       <= sel + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // sel is kept through IDLE, so dout keeps showing the last selected slice.
    assign dout = din[sel*WIDTH +: WIDTH];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter

module tb_mux_rr_arbiter;

    localparam int WIDTH = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         req;
    logic [8*WIDTH-1:0] din;
    logic               out_ready;
    logic               lock;
    logic [7:0]         gnt;
    logic [2:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   dout;

    logic [WIDTH-1:0] words [8];
    int               exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               exp_idx;

    mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
`ifdef MUX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int idx);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sel"},   32'(sel),       32'(idx));
        check({tag, "_gnt"},   32'(gnt),       32'(8'b1 << idx));
        check({tag, "_dout"},  32'(dout),      32'(words[idx]));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_gnt"},   32'(gnt),       32'd0);
    endtask

    // Each handshake seen on the output pops the next expected requester.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_xfer", 32'(sel), 32'hFFFF_FFFF);
            end else begin
                exp_idx = exp_q.pop_front();
                check("sb_sel",  32'(sel),  32'(exp_idx));
                check("sb_dout", 32'(dout), 32'(words[exp_idx]));
            end
        end
    end

    initial begin
        words[0] = 3'b000; words[1] = 3'b110; words[2] = 3'b100; words[3] = 3'b111;
        words[4] = 3'b101; words[5] = 3'b001; words[6] = 3'b011; words[7] = 3'b010;
        for (int i = 0; i < 8; i++) din[i*WIDTH +: WIDTH] = words[i];
        rst = 1'b1; req = 8'd0; out_ready = 1'b0; lock = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_gnt",   32'(gnt),       32'd0);
        check("rst_sel",   32'(sel),       32'd0);

        // Single request on index 3, accepted immediately.
        req = 8'b0000_1000; out_ready = 1'b1; exp_q.push_back(3);
        tick();
        expect_grant("single", 3);
        tick();
        req = 8'd0;
        expect_idle("single_done");
        tick();
        expect_idle("idle_no_req");

        // ptr must now be 4: with 3 and 4 requesting, 4 wins.
        req = 8'b0001_1000; exp_q.push_back(4);
        tick();
        expect_grant("ptr4", 4);
        tick();
        req = 8'd0;

        // Reset restores ptr to 0, then full round robin with a bubble each time.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
        for (int k = 0; k < 9; k++) begin
            tick();
            expect_grant($sformatf("rr%0d", k), k % 8);
            tick();
            check($sformatf("rr%0d_bubble", k), 32'(out_valid), 32'd0);
        end
        req = 8'd0;

        // Backpressure on index 5 for 4 cycles, then one transfer.
        req = 8'b0010_0000; out_ready = 1'b0; exp_q.push_back(5);
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_grant($sformatf("bp%0d", k), 5);
            if (k < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        req = 8'd0;
        expect_idle("bp_done");

        // ptr = 6: index 0 beats index 1 across the wrap, then ptr = 1.
        req = 8'b0000_0011; exp_q.push_back(0);
        tick();
        expect_grant("wrap", 0);
        tick();
        exp_q.push_back(1);
        tick();
        expect_grant("wrap_next", 1);
        tick();
        req = 8'd0;

        // Reset while busy on index 2 with backpressure drops the word.
        req = 8'b0000_0100; out_ready = 1'b0;
        tick();
        expect_grant("pre_rst", 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_idle("mid_rst");
        check("mid_rst_sel", 32'(sel), 32'd0);
        req = 8'hFF; out_ready = 1'b1; exp_q.push_back(0);
        tick();
        expect_grant("post_rst", 0);
        tick();
        req = 8'd0;

`ifdef MUX_ARB_LOCK_EN
        // ptr = 1 here; lock a burst of three words on index 3.
        req = 8'b0000_1000; lock = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(3);
        tick();
        expect_grant("lock0", 3);
        tick();
        expect_grant("lock1", 3);
        tick();
        lock = 1'b0;
        expect_grant("lock2", 3);
        tick();
        expect_idle("lock_end");
        req = 8'hFF; exp_q.push_back(4);
        tick();
        expect_grant("after_lock", 4);
        tick();
        req = 8'd0;
`endif

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
